sar_adc_ctrl: RTL

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

---
 rtl/sar_adc_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_ctrl
// Description : Successive-approximation ADC controller. It drives a 10-bit
//               trial code to an external R-2R DAC. It lets the DAC and the
//               comparator settle for SETTLE_CYCLES per bit, then keeps or
//               clears each bit from the synchronized comparator output.
//               The converter can run one-shot (start) or continuously (cont).
// Revision    : 1.0 - initial release
// ============================================================================
module sar_adc_ctrl #(
    parameter int SETTLE_CYCLES = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       cmp_in,
    output logic [9:0] dac_out,
    output logic       busy,
    output logic       valid,
    output logic [9:0] data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DECIDE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [9:0] TRIAL_INIT  = 10'h200;
    localparam logic [3:0] INDEX_INIT  = 4'd9;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       cmp_meta;
    logic       cmp_sync;
    logic [9:0] trial;
    logic [9:0] trial_nxt;
    logic [3:0] index;
    logic [7:0] settle_cnt;
    logic       settle_end;
    logic       begin_conv;

    assign settle_end = (settle_cnt == SETTLE_LAST);
    // A fresh conversion is armed from IDLE on request, or straight out of DONE in continuous mode.
    assign begin_conv = ((state == ST_IDLE) && (start || cont)) ||
                        ((state == ST_DONE) && cont);

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_meta <= 1'b0;
            cmp_sync <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_sync <= cmp_meta;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start || cont) state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_end) state_nxt = ST_DECIDE;
            ST_DECIDE: state_nxt = (index == 4'd0) ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_nxt = cont ? ST_SETTLE : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs; the trial register already holds the final code after DECIDE.
    always_comb begin
        busy    = (state != ST_IDLE);
        valid   = (state == ST_DONE);
        dac_out = trial;
    end

    // Bit decision: keep or clear the bit under test, then arm the next lower bit.
    always_comb begin
        trial_nxt        = trial;
        trial_nxt[index] = cmp_sync;
        if (index != 4'd0) begin
            trial_nxt[index - 4'd1] = 1'b1;
        end
    end

    // Conversion datapath: trial code, bit index, settle counter and result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trial      <= '0;
            index      <= '0;
            settle_cnt <= '0;
            data       <= '0;
        end else if (begin_conv) begin
            trial      <= TRIAL_INIT;
            index      <= INDEX_INIT;
            settle_cnt <= '0;
        end else begin
            case (state)
                ST_SETTLE: settle_cnt <= settle_cnt + 8'd1;
                ST_DECIDE: begin
                    trial <= trial_nxt;
                    if (index != 4'd0) begin
                        index      <= index - 4'd1;
                        settle_cnt <= '0;
                    end else begin
                        // Result becomes visible in the DONE cycle together with valid.
                        data <= trial_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
